// File: rtl/rsa_decrypt_unit_if.sv
// Ciphertext-in / plaintext-out handshake bundle for the RSA decrypt unit.
// The master drives ciphertexts and consumes results; the slave is the decrypt unit.
interface rsa_decrypt_unit_if;
    logic [12:0] cipher_in;
    logic        cipher_valid;
    logic        cipher_ready;
    logic [7:0]  plain_out;
    logic        plain_valid;
    logic        out_ready;
    logic        range_err;
    logic        busy;

    modport master (
        output cipher_in,
        output cipher_valid,
        output out_ready,
        input  cipher_ready,
        input  plain_out,
        input  plain_valid,
        input  range_err,
        input  busy
    );

    modport slave (
        input  cipher_in,
        input  cipher_valid,
        input  out_ready,
        output cipher_ready,
        output plain_out,
        output plain_valid,
        output range_err,
        output busy
    );
endinterface

// File: rtl/rsa_decrypt_unit.sv
// RSA decryption m = c^D mod N by left-to-right square-and-multiply,
// one modular multiply per cycle, with valid/ready handshakes on both sides.
module rsa_decrypt_unit #(
    parameter int N       = 3233,
    parameter int D       = 2753,
    parameter int N_WIDTH = 12,
    parameter int D_WIDTH = 12
) (
    input logic              clk,
    input logic              rst_n,
    rsa_decrypt_unit_if.slave bus
);
    localparam int IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam int P_W   = 2 * N_WIDTH;

    localparam logic [P_W-1:0]     N_WIDE = P_W'(N);
    localparam logic [D_WIDTH-1:0] D_BITS = D_WIDTH'(D);
    localparam logic [IDX_W-1:0]   TOP_IDX = IDX_W'(D_WIDTH - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SQUARE   = 2'd1;
    localparam logic [1:0] MULTIPLY = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [N_WIDTH-1:0] acc;
    logic [N_WIDTH-1:0] base;
    logic [IDX_W-1:0]   bit_idx;
    logic [7:0]         plain_out;
    logic               plain_valid;
    logic               range_err;
    logic               busy;

    logic [N_WIDTH-1:0] mul_operand;
    logic [P_W-1:0]     product;
    logic [N_WIDTH-1:0] product_mod;
    logic [N_WIDTH-1:0] cipher_mod;
    logic               exp_bit;

    assign bus.cipher_ready = (state == IDLE);
    assign bus.plain_out    = plain_out;
    assign bus.plain_valid  = plain_valid;
    assign bus.range_err    = range_err;
    assign bus.busy         = busy;

    // One shared multiplier: acc*acc while squaring, acc*base while multiplying.
    always_comb begin
        mul_operand = (state == MULTIPLY) ? base : acc;
        product     = P_W'(acc) * P_W'(mul_operand);
        product_mod = N_WIDTH'(product % N_WIDE);
        cipher_mod  = N_WIDTH'(P_W'(bus.cipher_in) % N_WIDE);
        exp_bit     = D_BITS[bit_idx];
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.cipher_valid) next_state = SQUARE;
            end
            SQUARE: begin
                if (exp_bit)             next_state = MULTIPLY;
                else if (bit_idx == '0)  next_state = DONE;
            end
            MULTIPLY: begin
                next_state = (bit_idx == '0) ? DONE : SQUARE;
            end
            DONE: begin
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            base        <= '0;
            bit_idx     <= '0;
            plain_out   <= '0;
            plain_valid <= 1'b0;
            range_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state == SQUARE) || (next_state == MULTIPLY);
            plain_valid <= (next_state == DONE);

            case (state)
                IDLE: begin
                    if (bus.cipher_valid) begin
                        base    <= cipher_mod;
                        acc     <= N_WIDTH'(1);
                        bit_idx <= TOP_IDX;
                    end
                end
                SQUARE: begin
                    acc <= product_mod;
                    if (!exp_bit && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
                end
                MULTIPLY: begin
                    acc <= product_mod;
                    if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
                end
                default: ;
            endcase

            // Capture the final product on the edge that enters DONE so the result is valid immediately.
            if (state != DONE && next_state == DONE) begin
                plain_out <= product_mod[7:0];
                range_err <= (product_mod > N_WIDTH'(255));
            end
        end
    end
endmodule

// File: tb/tb_rsa_decrypt_unit.sv
// Self-checking bench for rsa_decrypt_unit: directed cases plus random ciphertexts
// compared against a repeated-multiplication modular exponent model.
module tb_rsa_decrypt_unit;
    localparam int N_MOD   = 3233;
    localparam int D_EXP   = 2753;
    localparam int E_EXP   = 17;
    localparam int LATENCY = 17;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    rsa_decrypt_unit_if bus ();

    rsa_decrypt_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint mod_pow(input longint b, input int e);
        longint r;
        longint bb;
        r  = 1;
        bb = b % N_MOD;
        for (int i = 0; i < e; i++) r = (r * bb) % N_MOD;
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Waits for IDLE, presents c for one accepting edge; returns at #1 after the accept edge.
    task automatic apply_stimulus(input logic [12:0] c);
        int guard;
        guard = 0;
        while (bus.cipher_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output("ready_wait_timeout", 32'(guard < 50), 32'd1);
        bus.cipher_in    = c;
        bus.cipher_valid = 1'b1;
        @(posedge clk); #1;
        bus.cipher_valid = 1'b0;
        check_output("busy_after_accept", 32'(bus.busy), 32'd1);
        check_output("ready_low_after_accept", 32'(bus.cipher_ready), 32'd0);
    endtask

    // Counts edges from the accept edge until plain_valid and checks latency and result.
    task automatic wait_result(input string tag, input longint full);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.plain_valid !== 1'b1 && k < 60);
        check_output({tag, "_latency"}, 32'(k), 32'(LATENCY));
        check_output({tag, "_plain"}, 32'(bus.plain_out), 32'(full & 255));
        check_output({tag, "_range"}, 32'(bus.range_err), 32'(full > 255));
        check_output({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        check_output({tag, "_ready_done"}, 32'(bus.cipher_ready), 32'd0);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_output({tag, "_valid_drop"}, 32'(bus.plain_valid), 32'd0);
        check_output({tag, "_ready_back"}, 32'(bus.cipher_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  held_plain;
        logic        held_range;
        logic [12:0] rc;
        longint      m;

        tests_run        = 0;
        tests_failed     = 0;
        rst_n            = 1'b0;
        bus.cipher_in    = '0;
        bus.cipher_valid = 1'b0;
        bus.out_ready    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_valid", 32'(bus.plain_valid), 32'd0);
        check_output("reset_plain", 32'(bus.plain_out), 32'd0);
        check_output("reset_range", 32'(bus.range_err), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_ready", 32'(bus.cipher_ready), 32'd1);
        rst_n = 1'b1;

        // Textbook vector with out_ready held high throughout.
        bus.out_ready = 1'b1;
        apply_stimulus(13'd2790);
        wait_result("c2790", 65);
        consume("c2790");

        // Zero then one, second request held on the consuming edge.
        apply_stimulus(13'd0);
        wait_result("c0", mod_pow(0, D_EXP));
        bus.out_ready    = 1'b1;
        bus.cipher_in    = 13'd1;
        bus.cipher_valid = 1'b1;
        @(posedge clk); #1;
        check_output("b2b_no_same_edge_accept", 32'(bus.busy), 32'd0);
        check_output("b2b_ready_idle", 32'(bus.cipher_ready), 32'd1);
        check_output("b2b_valid_drop", 32'(bus.plain_valid), 32'd0);
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.cipher_valid = 1'b0;
        check_output("b2b_accept_next_edge", 32'(bus.busy), 32'd1);
        wait_result("c1", 1);
        consume("c1");

        // Inputs at or above the modulus are reduced first.
        apply_stimulus(13'd3233);
        wait_result("c3233", 0);
        consume("c3233");
        apply_stimulus(13'd3234);
        wait_result("c3234", 1);
        consume("c3234");

        // -1 mod N with odd D stays -1, which overflows 8 bits.
        apply_stimulus(13'd3232);
        wait_result("c3232", 3232);

        // Stall the consumer and pulse a stray request while DONE.
        held_plain = bus.plain_out;
        held_range = bus.range_err;
        for (int i = 0; i < 5; i++) begin
            bus.cipher_in    = 13'd7;
            bus.cipher_valid = (i == 2);
            @(posedge clk); #1;
            check_output("stall_valid", 32'(bus.plain_valid), 32'd1);
            check_output("stall_plain", 32'(bus.plain_out), 32'(held_plain));
            check_output("stall_range", 32'(bus.range_err), 32'(held_range));
            check_output("stall_ready", 32'(bus.cipher_ready), 32'd0);
        end
        bus.cipher_valid = 1'b0;
        consume("stall");
        check_output("stall_pulse_ignored", 32'(bus.busy), 32'd0);

        // Reset in the middle of a computation, then a clean request.
        apply_stimulus(13'd2790);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_output("midrst_valid", 32'(bus.plain_valid), 32'd0);
        check_output("midrst_plain", 32'(bus.plain_out), 32'd0);
        check_output("midrst_range", 32'(bus.range_err), 32'd0);
        check_output("midrst_busy", 32'(bus.busy), 32'd0);
        check_output("midrst_idle", 32'(bus.cipher_ready), 32'd1);
        apply_stimulus(13'd2790);
        wait_result("after_rst", 65);
        consume("after_rst");

        // Random round trips through encryption and random raw ciphertexts.
        for (int i = 0; i < 6; i++) begin
            m = longint'($urandom_range(0, 255));
            rc = 13'(mod_pow(m, E_EXP));
            apply_stimulus(rc);
            wait_result("rand_roundtrip", m);
            consume("rand_roundtrip");
        end
        for (int i = 0; i < 6; i++) begin
            rc = 13'($urandom_range(0, 8191));
            apply_stimulus(rc);
            wait_result("rand_raw", mod_pow(longint'(rc), D_EXP));
            consume("rand_raw");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
